// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_seq_pkg                                                   |
// | Purpose : Op codes, FSM state type and op-class helpers shared by the      |
// |           multi-cycle RV64M multiply/divide sequencer.                     |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package muldiv_seq_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_MULW   = 4'd4,
    OP_DIV    = 4'd5,
    OP_DIVU   = 4'd6,
    OP_REM    = 4'd7,
    OP_REMU   = 4'd8,
    OP_DIVW   = 4'd9,
    OP_DIVUW  = 4'd10,
    OP_REMW   = 4'd11,
    OP_REMUW  = 4'd12
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // 32-bit "W" forms: operate on the low half, sign-extend the result
  function automatic logic is_w_op(input logic [OP_W-1:0] op);
    return (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
           (op == OP_REMW) || (op == OP_REMUW);
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op >= OP_DIV) && (op <= OP_REMUW);
  endfunction

  function automatic logic is_sdiv_op(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
  endfunction

  function automatic logic is_rem_op(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_seq_if                                                    |
// | Purpose : Request/response bundle between EXU issue logic and muldiv_seq.  |
// | Ports   : flush, in_valid/in_ready/op/src1/src2 (request),                 |
// |           out_valid/out_ready/result (response)                            |
// |           master = requester/consumer, slave = sequencer                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface muldiv_seq_if
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output flush, in_valid, op, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  flush, in_valid, op, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mdu_div_step                                                     |
// | Purpose : One combinational restoring-division step. Shifts {rem,quo}      |
// |           left by one, trial-subtracts the divisor and records the         |
// |           quotient bit.                                                    |
// | Ports   : rem_in/quo_in/divisor -> rem_out/quo_out                         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module mdu_div_step
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;
  logic          w_ge;

  always_comb begin
    w_shift = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
    // A set top bit means the true shifted value is >= 2^(XLEN+1), which is
    // always above the divisor; the wrapped difference is still exact then.
    w_ge    = rem_in[XLEN] || (w_shift >= {1'b0, divisor});
    w_diff  = w_shift - {1'b0, divisor};
    rem_out = w_ge ? w_diff : w_shift;
    quo_out = {quo_in[XLEN-2:0], w_ge};
  end
endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : muldiv_seq                                                       |
// | Purpose : Multi-cycle RV64M sequencer: radix-2 shift-add multiplier and    |
// |           restoring divider on magnitudes, sign fix-up, W-op handling.     |
// | Ports   : clk, rst (async, active-high), bus (muldiv_seq_if.slave)         |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_seq_if.slave   bus
);
  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN + 1);

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext_half(input logic [HALF-1:0] v);
    return {{HALF{1'b0}}, v};
  endfunction

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_op;
  logic [XLEN-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_prod;
  logic [XLEN:0]     r_rem;
  logic [XLEN-1:0]   r_quo;
  logic              r_neg_q;   // negate product / quotient at fix-up
  logic              r_neg_r;   // negate remainder at fix-up
  logic [XLEN-1:0]   r_result;

  // ---------------- accept-time decode ----------------
  logic            w_accept, w_is_w, w_is_div, w_sdiv, w_is_rem;
  logic [XLEN-1:0] w_dd_ext, w_dv_ext, w_dd_mag, w_dv_mag, w_dd_res;
  logic            w_dd_neg, w_dv_neg, w_dv_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_mul_sa, w_mul_sb;
  logic [XLEN-1:0] w_mcand, w_mplier;

  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    w_is_w   = is_w_op(bus.op);
    w_is_div = is_div_op(bus.op);
    w_sdiv   = is_sdiv_op(bus.op);
    w_is_rem = is_rem_op(bus.op);

    if (w_is_w) begin
      w_dd_ext = w_sdiv ? sext_half(bus.src1[HALF-1:0]) : zext_half(bus.src1[HALF-1:0]);
      w_dv_ext = w_sdiv ? sext_half(bus.src2[HALF-1:0]) : zext_half(bus.src2[HALF-1:0]);
      w_ovf    = w_sdiv && (bus.src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) &&
                 (&bus.src2[HALF-1:0]);
      w_dd_res = sext_half(bus.src1[HALF-1:0]);
    end else begin
      w_dd_ext = bus.src1;
      w_dv_ext = bus.src2;
      w_ovf    = w_sdiv && (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.src2);
      w_dd_res = bus.src1;
    end

    w_dd_neg  = w_sdiv && w_dd_ext[XLEN-1];
    w_dv_neg  = w_sdiv && w_dv_ext[XLEN-1];
    w_dd_mag  = w_dd_neg ? -w_dd_ext : w_dd_ext;
    w_dv_mag  = w_dv_neg ? -w_dv_ext : w_dv_ext;
    w_dv_zero = (w_dv_ext == '0);
    w_special = w_is_div && (w_dv_zero || w_ovf);

    if (w_is_rem) w_special_res = w_dv_zero ? w_dd_res : '0;
    else          w_special_res = w_dv_zero ? '1 : w_dd_res;

    // MUL/MULW keep raw bits: the low product half does not depend on sign
    w_mul_sa = ((bus.op == OP_MULH) || (bus.op == OP_MULHSU)) && bus.src1[XLEN-1];
    w_mul_sb = (bus.op == OP_MULH) && bus.src2[XLEN-1];
    if (bus.op == OP_MULW) begin
      w_mcand  = zext_half(bus.src1[HALF-1:0]);
      w_mplier = zext_half(bus.src2[HALF-1:0]);
    end else begin
      w_mcand  = w_mul_sa ? -bus.src1 : bus.src1;
      w_mplier = w_mul_sb ? -bus.src2 : bus.src2;
    end
  end

  // ---------------- iteration datapath ----------------
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_prod_nxt;
  logic [XLEN:0]     w_rem_nxt;
  logic [XLEN-1:0]   w_quo_nxt;

  always_comb begin
    w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_opnd} : '0);
    w_prod_nxt = {w_mul_sum, r_prod[XLEN-1:1]};
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_opnd),
    .rem_out (w_rem_nxt),
    .quo_out (w_quo_nxt)
  );

  // ---------------- sign fix-up and result select ----------------
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fix_res;

  always_comb begin
    w_prod_fix = r_neg_q ? -r_prod : r_prod;
    w_quo_fix  = r_neg_q ? -r_quo : r_quo;
    w_rem_fix  = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];
    w_fix_res  = '0;
    case (r_op)
      OP_MUL:                        w_fix_res = r_prod[XLEN-1:0];
      // a 32-iteration run leaves the 64-bit product in r_prod[2*XLEN-1:HALF]
      OP_MULW:                       w_fix_res = sext_half(r_prod[XLEN-1:HALF]);
      OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_fix_res = w_quo_fix;
      OP_REM, OP_REMU:               w_fix_res = w_rem_fix;
      OP_DIVW, OP_DIVUW:             w_fix_res = sext_half(w_quo_fix[HALF-1:0]);
      OP_REMW, OP_REMUW:             w_fix_res = sext_half(w_rem_fix[HALF-1:0]);
      default:                       w_fix_res = '0;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == CNT_W'(1)) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) w_state_nxt = S_IDLE;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_opnd   <= '0;
      r_prod   <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op  <= bus.op;
      r_cnt <= w_is_w ? CNT_W'(HALF) : CNT_W'(XLEN);
      if (w_is_div) begin
        r_opnd  <= w_dv_mag;
        r_rem   <= '0;
        // W dividends are left-aligned so 32 steps consume exactly their bits
        r_quo   <= w_is_w ? {w_dd_mag[HALF-1:0], {HALF{1'b0}}} : w_dd_mag;
        r_neg_q <= w_dd_neg ^ w_dv_neg;
        r_neg_r <= w_dd_neg;
      end else begin
        r_opnd  <= w_mcand;
        r_prod  <= {{XLEN{1'b0}}, w_mplier};
        r_neg_q <= w_mul_sa ^ w_mul_sb;
        r_neg_r <= 1'b0;
      end
      if (w_special) r_result <= w_special_res;
    end else if (r_state == S_CALC) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (is_div_op(r_op)) begin
        r_rem <= w_rem_nxt;
        r_quo <= w_quo_nxt;
      end else begin
        r_prod <= w_prod_nxt;
      end
    end else if ((r_state == S_FIX) && !bus.flush) begin
      r_result <= w_fix_res;
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !bus.flush;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.result    = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_muldiv_seq                                                    |
// | Purpose : Self-checking bench for muldiv_seq: arithmetic reference model,  |
// |           per-cycle compare of handshake/result, directed literal cases,   |
// |           randomized traffic with backpressure and flushes.                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(64)) bus ();

  muldiv_seq #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sp;
    logic        [127:0] up;
    logic signed [63:0]  sa, sb, sq;
    logic signed [31:0]  sa32, sb32, sq32;
    logic        [31:0]  a32, b32, p32;
    logic                ovf64, ovf32;
    sa = a; sb = b; a32 = a[31:0]; b32 = b[31:0]; sa32 = a32; sb32 = b32;
    ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    ovf32 = (a32 == 32'h8000_0000) && (b32 == '1);
    case (op)
      OP_MUL:    return a * b;
      OP_MULH:   begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return sp[127:64]; end
      OP_MULHSU: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'b0, b}); return sp[127:64]; end
      OP_MULHU:  begin up = {64'b0, a} * {64'b0, b}; return up[127:64]; end
      OP_MULW:   begin p32 = a32 * b32; return sx32(p32); end
      OP_DIV:    begin if (b == 0) return '1; if (ovf64) return a; sq = sa / sb; return sq; end
      OP_DIVU:   return (b == 0) ? '1 : a / b;
      OP_REM:    begin if (b == 0) return a; if (ovf64) return '0; sq = sa % sb; return sq; end
      OP_REMU:   return (b == 0) ? a : a % b;
      OP_DIVW:   begin if (b32 == 0) return '1; if (ovf32) return sx32(a32); sq32 = sa32 / sb32; return sx32(sq32); end
      OP_DIVUW:  return (b32 == 0) ? '1 : sx32(a32 / b32);
      OP_REMW:   begin if (b32 == 0) return sx32(a32); if (ovf32) return '0; sq32 = sa32 % sb32; return sx32(sq32); end
      OP_REMUW:  return (b32 == 0) ? sx32(a32) : sx32(a32 % b32);
      default:   return '0;
    endcase
  endfunction

  // cycles from accept edge to the edge that first samples out_valid
  function automatic int ref_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, dv, sd, zero, ovf;
    w  = (op == OP_MULW) || (op >= OP_DIVW && op <= OP_REMUW);
    dv = (op >= OP_DIV) && (op <= OP_REMUW);
    sd = (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf  = sd && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                    : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (dv && (zero || ovf)) return 1;
    return w ? 34 : 66;
  endfunction

  bit          m_busy;
  int          m_left;
  logic [63:0] m_exp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_left <= 0;
    end else if (bus.flush) begin
      m_busy <= 1'b0;
    end else if (m_busy) begin
      if (m_left == 0) begin
        if (bus.out_ready) m_busy <= 1'b0;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (bus.in_valid) begin
      m_busy <= 1'b1;
      m_left <= ref_lat(bus.op, bus.src1, bus.src2) - 1;
      m_exp  <= ref_res(bus.op, bus.src1, bus.src2);
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        checks++;
        if (bus.out_valid !== (m_busy && m_left == 0)) begin
          errors++;
          $display("FAIL out_valid t=%0t actual=%b required=%b", $time, bus.out_valid, (m_busy && m_left == 0));
        end
        checks++;
        if (bus.in_ready !== (!m_busy && !bus.flush)) begin
          errors++;
          $display("FAIL in_ready t=%0t actual=%b required=%b", $time, bus.in_ready, (!m_busy && !bus.flush));
        end
        if (m_busy && m_left == 0 && bus.out_valid) begin
          checks++;
          if (bus.result !== m_exp) begin
            errors++;
            $display("FAIL result t=%0t actual=%h required=%h", $time, bus.result, m_exp);
          end
        end
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic start_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.op = op; bus.src1 = a; bus.src2 = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] req, input int req_lat, input bit release_out);
    int lat;
    bus.out_ready = 1'b0;
    start_op(op, a, b);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    check({name, "_lat"}, 64'(lat), 64'(req_lat));
    check({name, "_res"}, bus.result, req);
    if (release_out) begin
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
  endtask

  function automatic logic [63:0] rnd_opnd();
    case ($urandom % 8)
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom % 16);
      4: return {32'($urandom), 32'h8000_0000};
      5: return {32'($urandom), 32'hFFFF_FFFF};
      6: return -64'($urandom % 16);
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.op = '0;
    bus.src1 = '0; bus.src2 = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    run_op("mul", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 66, 1'b1);
    run_op("divu0", OP_DIVU, 64'd7, 64'd0, '1, 1, 1'b1);
    run_op("remu0", OP_REMU, 64'd7, 64'd0, 64'd7, 1, 1'b1);
    run_op("remw0", OP_REMW, 64'h1_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1, 1'b1);
    run_op("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1'b1);
    run_op("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1'b1);
    run_op("divw", OP_DIVW, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b1);
    run_op("remw", OP_REMW, 64'hFFFF_FFF9, 64'd2, '1, 34, 1'b1);

    // backpressure: result held, no new accept
    run_op("mulhu", OP_MULHU, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);

    // flush in the middle of a divide
    start_op(OP_DIV, 64'd100, 64'd7);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    run_op("mulhsu", OP_MULHSU, '1, 64'd2, '1, 66, 1'b1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom % 4) != 0;
      bus.op        = 4'($urandom_range(0, 12));
      bus.src1      = rnd_opnd();
      bus.src2      = rnd_opnd();
      bus.out_ready = ($urandom % 4) != 0;
      bus.flush     = ($urandom % 150) == 0;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1 bus.out_ready = 1'b0;

    // async reset in the middle of an op clears everything at once
    start_op(OP_MUL, 64'd5, 64'd9);
    repeat (20) @(posedge clk);
    #1 chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_result", bus.result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
